// File: rtl/sfifo_wr_arbiter_if.sv
// rtl/sfifo_wr_arbiter_if.sv - producer-side and sfifo write-port signals shared by the arbiter
interface sfifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wready;
    logic                  fifo_full;
    logic                  fifo_wreq;
    logic [WIDTH-1:0]      fifo_wdata;

    modport master (
        output req_valid, req_data, req_last, fifo_wready, fifo_full,
        input  req_ready, fifo_wreq, fifo_wdata
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_wready, fifo_full,
        output req_ready, fifo_wreq, fifo_wdata
    );
endinterface

// File: rtl/sfifo_wr_arbiter.sv
// rtl/sfifo_wr_arbiter.sv - round-robin burst write arbiter for one sfifo write port
// Optional macro SFIFO_ARB_PRIO0_EN: requester 0 gets strict priority at arbitration time.
module sfifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int IDXW      = 2,
    parameter int MAX_BURST = 4,
    parameter int BCW       = 3
) (
    input  logic                clk,
    input  logic                reset,
    sfifo_wr_arbiter_if.slave   bus,
    output logic [IDXW-1:0]     grant_id,
    output logic                busy
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]      state;
    logic [IDXW-1:0] rr_ptr;
    logic [BCW-1:0]  burst_cnt;
    logic [NREQ-1:0] cand;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic            can_take;
    logic            beat;
    logic            release_g;
    logic [IDXW-1:0] next_ptr;

    // Walk offsets from the far end so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = bus.req_valid;
`ifdef SFIFO_ARB_PRIO0_EN
        cand[0]  = 1'b0;
`endif
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (cand[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(idx);
            end
        end
`ifdef SFIFO_ARB_PRIO0_EN
        if (bus.req_valid[0]) begin
            pick_vld = 1'b1;
            pick_idx = '0;
        end
`endif
    end

    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_wreq  = 1'b0;
        bus.fifo_wdata = '0;
        can_take       = bus.fifo_wready & ~bus.fifo_full;
        beat           = 1'b0;
        release_g      = 1'b0;
        if (state == S_GRANT) begin
            bus.req_ready[grant_id] = can_take;
            beat          = bus.req_valid[grant_id] & can_take;
            bus.fifo_wreq = beat;
            if (beat)
                bus.fifo_wdata = bus.req_data[grant_id*WIDTH +: WIDTH];
            // Back-pressure alone never releases; an idle holder always does.
            release_g = ~bus.req_valid[grant_id] |
                        (beat & (bus.req_last[grant_id] |
                                 (burst_cnt == BCW'(MAX_BURST - 1))));
        end
    end

    assign next_ptr = (grant_id == IDXW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy     = (state == S_GRANT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (beat)
                        burst_cnt <= burst_cnt + 1'b1;
                    if (release_g) begin
                        state <= S_IDLE;
`ifdef SFIFO_ARB_PRIO0_EN
                        if (grant_id != '0)
                            rr_ptr <= next_ptr;
`else
                        rr_ptr <= next_ptr;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// tb/tb_sfifo_wr_arbiter.sv - scoreboard bench for sfifo_wr_arbiter with directed vectors
module tb_sfifo_wr_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;

    sfifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

    sfifo_wr_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .IDXW(2), .MAX_BURST(4), .BCW(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .grant_id(grant_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    int         compared   = 0;
    int         mismatched = 0;
    beat_t      exp_q[$];
    beat_t      exp_b;
    logic [3:0] vld;
    int         cnt[4];
    int         last_at[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Requester i presents beat value i*16 + cnt[i]; req_last marks cnt[i]==last_at[i].
    task automatic drive();
        bus.req_valid = vld;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*WIDTH +: WIDTH] = 8'(i * 16 + cnt[i]);
            bus.req_last[i] = (cnt[i] == last_at[i]);
        end
    endtask

    task automatic push(input int id, input int c);
        exp_q.push_back({2'(id), 8'(id * 16 + c)});
    endtask

    task automatic step();
        logic [3:0] acc;
        @(negedge clk);
        acc = vld & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                if (cnt[i] == last_at[i]) vld[i] = 1'b0;
                cnt[i]++;
            end
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vld != 4'b0) && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check("drain_done", {31'b0, (exp_q.size() == 0 && vld == 4'b0)}, 1);
    endtask

    task automatic step_until(input int idx, input int target, input int budget);
        int n;
        n = 0;
        while (cnt[idx] != target && n < budget) begin
            step();
            n++;
        end
        check("reach_beat", cnt[idx], target);
    endtask

    always @(negedge clk) begin
        if (bus.fifo_wreq === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_beat: got data %0h id %0d, expected no beat",
                         bus.fifo_wdata, grant_id);
            end else begin
                exp_b = exp_q.pop_front();
                check("beat_data", bus.fifo_wdata, exp_b.data);
                check("beat_id", grant_id, exp_b.id);
                check("ready_onehot", bus.req_ready, 4'b0001 << exp_b.id);
                check("no_write_when_full", bus.fifo_full, 0);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        vld             = 4'b0;
        bus.fifo_wready = 1'b1;
        bus.fifo_full   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]     = 0;
            last_at[i] = 255;
        end
        drive();

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_wreq", bus.fifo_wreq, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_wdata", bus.fifo_wdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All four valid, no last: 4-beat bursts in order 0,1,2,3,0 with one bubble each
        for (int g = 0; g < 4; g++)
            for (int b = 0; b < 4; b++) push(g, b);
        for (int b = 4; b < 8; b++) push(0, b);
        vld = 4'b1111;
        drive();
        repeat (25) step();
        vld = 4'b0000;
        drive();
        repeat (2) step();
        check("rr_sequence_done", exp_q.size(), 0);

        // Requester 2 ends its burst after 2 beats; next pick starts at 3
        last_at[2] = 5;
        vld = 4'b0100;
        push(2, 4);
        push(2, 5);
        drive();
        drain(20);
        last_at[3] = 4;
        last_at[0] = 8;
        vld = 4'b1001;
        push(3, 4);
        push(0, 8);
        drive();
        drain(20);

        // FIFO full for 5 cycles at beat 3; burst resumes, ends at MAX_BURST, lone requester re-granted
        last_at[1] = 8;
        vld = 4'b0010;
        for (int b = 4; b <= 8; b++) push(1, b);
        drive();
        step_until(1, 6, 20);
        bus.fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("full_no_wreq", bus.fifo_wreq, 0);
            check("full_busy", busy, 1);
            check("full_grant_held", grant_id, 1);
            @(posedge clk);
            #1;
        end
        bus.fifo_full = 1'b0;
        drain(30);

        // Reset mid-burst of requester 1: outputs drop at once, requester 0 wins afterwards
        last_at[1] = 255;
        vld = 4'b0010;
        push(1, 9);
        push(0, 9);
        push(1, 10);
        drive();
        step_until(1, 10, 20);
        vld[0]     = 1'b1;
        last_at[0] = 9;
        drive();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_wreq", bus.fifo_wreq, 0);
        check("midrst_ready", bus.req_ready, 0);
        check("midrst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        last_at[1] = 10;
        drive();
        drain(30);

        // Requester 0 joins during requester 1's burst (last beat coincides with MAX_BURST)
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        last_at[1] = 14;
        last_at[3] = 5;
        last_at[0] = 10;
        vld = 4'b1010;
        for (int b = 11; b <= 14; b++) push(1, b);
`ifdef SFIFO_ARB_PRIO0_EN
        push(0, 10);
        push(3, 5);
`else
        push(3, 5);
        push(0, 10);
`endif
        drive();
        step_until(1, 12, 20);
        vld[0] = 1'b1;
        drive();
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
